// File: rtl/sc_fifo_xp.sv
// sc_fifo_xp: parametrised single-clock FIFO with guarded read/write,
// programmable almost-full/almost-empty levels and a registered output
// stage. FWFT=0 gives a standard registered read; FWFT=1 gives
// first-word-fall-through. Defining SC_FIFO_XP_ERR_EN adds sticky
// overflow/underflow flags; otherwise those outputs are tied low.
module sc_fifo_xp #(
  parameter int AW     = 5,
  parameter int DW     = 64,
  parameter int AF_LVL = 22,
  parameter int AE_LVL = 5,
  parameter int FWFT   = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] din,
  input  logic          wr,
  output logic          full,
  output logic          almost_full,
  input  logic          rd,
  output logic [DW-1:0] dout,
  output logic          dout_vld,
  output logic          empty,
  output logic          almost_empty,
  output logic [AW:0]   fifo_cntr,
  input  logic          err_clr,
  output logic          overflow,
  output logic          underflow
);

  localparam int          DEPTH   = 2 ** AW;
  localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);
  localparam logic [AW:0] AF_C    = (AW + 1)'(AF_LVL);
  localparam logic [AW:0] AE_C    = (AW + 1)'(AE_LVL);
  localparam logic [AW:0] CNT_ONE = (AW + 1)'(1);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   cntr;
  logic [AW:0]   mem_cntr;
  // In FWFT mode this is the output-stage valid flag; in standard mode it
  // is the one-cycle pulse that marks freshly loaded dout.
  logic          out_vld;
  logic          wr_acc;
  logic          rd_acc;
  logic          mem_rd;

  assign full         = (cntr == DEPTH_C);
  assign almost_full  = (cntr >= AF_C);
  assign almost_empty = (cntr <= AE_C);
  assign empty        = (FWFT != 0) ? ~out_vld : (cntr == '0);
  assign fifo_cntr    = cntr;
  assign dout_vld     = out_vld;

  assign wr_acc = wr & ~full;
  assign rd_acc = rd & ~empty;

  // Words still sitting in memory: the FWFT stage word is counted in cntr
  // but has already left the array.
  assign mem_cntr = (FWFT != 0) ? (cntr - {{AW{1'b0}}, out_vld}) : cntr;

  // FWFT refills the stage whenever it is empty or being consumed; standard
  // mode only reads memory on an accepted read.
  assign mem_rd = (FWFT != 0) ? ((~out_vld | rd_acc) & (mem_cntr != '0)) : rd_acc;

  // Storage array; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_acc && !rst) begin
      mem[wr_ptr] <= din;
    end
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cntr   <= '0;
    end else begin
      if (wr_acc) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (mem_rd) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({wr_acc, rd_acc})
        2'b10:   cntr <= cntr + CNT_ONE;
        2'b01:   cntr <= cntr - CNT_ONE;
        default: cntr <= cntr;
      endcase
    end
  end

  // Registered output stage: data register plus its valid/pulse flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      dout    <= '0;
      out_vld <= 1'b0;
    end else begin
      if (mem_rd) begin
        dout <= mem[rd_ptr];
      end
      if (FWFT != 0) begin
        if (mem_rd) begin
          out_vld <= 1'b1;
        end else if (rd_acc) begin
          out_vld <= 1'b0;
        end
      end else begin
        out_vld <= rd_acc;
      end
    end
  end

`ifdef SC_FIFO_XP_ERR_EN
  // Sticky error flags; a new error in the same cycle beats err_clr.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr && full) begin
        overflow <= 1'b1;
      end else if (err_clr) begin
        overflow <= 1'b0;
      end
      if (rd && empty) begin
        underflow <= 1'b1;
      end else if (err_clr) begin
        underflow <= 1'b0;
      end
    end
  end
`else
  logic unused_err_clr;
  assign unused_err_clr = err_clr;
  assign overflow       = 1'b0;
  assign underflow      = 1'b0;
`endif

endmodule
